// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: three-stage posit decoder with a valid/ready stream interface.
// S1 takes the magnitude and flags zero and NaR. S2 measures the regime run and
// strips it. S3 splits the exponent from the fraction and forms the scale.
module posit_decode_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  localparam int RW = $clog2(N) + 1,
  localparam int FW = N - 3 - ES,
  localparam int SW = RW + ES,
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exponent,
  output logic [FW-1:0]        out_fraction,
  output logic signed [SW-1:0] out_scale
);

  // Width of the regime run counter. It can hold up to N-1.
  localparam int MW = $clog2(N);

  // Ready chain. It is combinational, so bubbles collapse.
  logic w_rdy1, w_rdy2, w_rdy3;
  logic r_v1, r_v2, r_v3;

  assign w_rdy3   = !r_v3 || out_ready;
  assign w_rdy2   = !r_v2 || w_rdy3;
  assign w_rdy1   = !r_v1 || w_rdy2;
  assign in_ready = w_rdy1;

  // ---------------- Stage 1: magnitude and special flags ----------------
  // Only the low N-1 bits of the magnitude matter. Negating mod 2^(N-1) gives the same bits.
  logic [N-2:0] w_mag;
  assign w_mag = in_posit[N-1] ? (~in_posit[N-2:0] + (N-1)'(1)) : in_posit[N-2:0];

  logic         r1_sign, r1_zero, r1_nar;
  logic [N-2:0] r1_mag;

  // S1 valid bit. It advances whenever S1 can accept a word.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments. Every stage then samples the value
    // its neighbour held before the edge.
    if (!rst_n)      r_v1 <= 1'b0;
    else if (w_rdy1) r_v1 <= in_valid;
  end

  // S1 payload. It loads regardless of valid.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are deliberately not reset. The valid bits alone decide
    // whether their contents mean anything.
    if (w_rdy1) begin
      r1_sign <= in_posit[N-1];
      r1_zero <= (in_posit == '0);
      r1_nar  <= (in_posit == {1'b1, {(N-1){1'b0}}});
      r1_mag  <= w_mag;
    end
  end

  // ---------------- Stage 2: regime run length and body ----------------
  logic [MW-1:0]        w_run;
  logic                 w_run_done;
  logic signed [RW-1:0] w_run_s;
  logic signed [RW-1:0] w_k;
  logic [N-4:0]         w_body;

  // Count how many bits from mag[N-2] downward equal mag[N-2]. The count is capped at N-1.
  always_comb begin
    // NOTE: every variable gets its default before the loop. Nothing is left to hold
    // its old value, so no latch is inferred.
    w_run      = MW'(1);
    w_run_done = 1'b0;
    for (int i = N - 3; i >= 0; i--) begin
      if (!w_run_done && (r1_mag[i] == r1_mag[N-2])) w_run = w_run + MW'(1);
      else                                           w_run_done = 1'b1;
    end
  end

  assign w_run_s = signed'({1'b0, w_run});
  assign w_k     = r1_mag[N-2] ? (w_run_s - RW'(1)) : -w_run_s;
  // Dropping the m regime bits and the terminator is a left shift by m-1 of mag[N-4:0].
  // Any run of N-2 or more leaves the body empty.
  assign w_body  = r1_mag[N-4:0] << (w_run - MW'(1));

  logic                 r2_sign, r2_zero, r2_nar;
  logic signed [RW-1:0] r2_k;
  logic [N-4:0]         r2_body;

  // S2 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_v2 <= 1'b0;
    else if (w_rdy2) r_v2 <= r_v1;
  end

  // S2 payload: regime value and the left-aligned body.
  always_ff @(posedge clk) begin
    if (w_rdy2) begin
      r2_sign <= r1_sign;
      r2_zero <= r1_zero;
      r2_nar  <= r1_nar;
      r2_k    <= w_k;
      r2_body <= w_body;
    end
  end

  // ---------------- Stage 3: exponent, fraction, scale ----------------
  logic [EW-1:0]        w_exp;
  logic [FW-1:0]        w_frac;
  logic signed [SW-1:0] w_k_ext;
  logic signed [SW-1:0] w_scale;
  logic                 w_special;

  generate
    if (ES > 0) begin : g_exp
      assign w_exp = r2_body[N-4 -: ES];
    end else begin : g_no_exp
      assign w_exp = 1'b0;
    end
  endgenerate

  assign w_frac    = r2_body[FW-1:0];
  assign w_k_ext   = SW'(r2_k);
  assign w_scale   = SW'(w_k_ext <<< ES) + SW'(w_exp);
  assign w_special = r2_zero || r2_nar;

  // Output register. It is cleared on reset, and zero and NaR force the fields to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v3          <= 1'b0;
      out_sign      <= 1'b0;
      out_zero      <= 1'b0;
      out_nar       <= 1'b0;
      out_regime    <= '0;
      out_exponent  <= '0;
      out_fraction  <= '0;
      out_scale     <= '0;
    end else if (w_rdy3) begin
      r_v3          <= r_v2;
      out_sign      <= r2_sign;
      out_zero      <= r2_zero;
      out_nar       <= r2_nar;
      out_regime    <= w_special ? '0 : r2_k;
      out_exponent  <= w_special ? '0 : w_exp;
      out_fraction  <= w_special ? '0 : w_frac;
      out_scale     <= w_special ? '0 : w_scale;
    end
  end

  assign out_valid = r_v3;

endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Parametrised, pipelined posit decoder: generic width N and exponent size ES.
- Unpacks a posit word into sign, zero/NaR flags, regime, exponent, fraction and combined scale.
- Has a valid/ready stream interface and a 3-stage registered pipeline with per-stage backpressure.
- Sits at the front of the posit arithmetic datapath and feeds the add/mul units.

Parameters:
- N, 32, posit width in bits; legal range 8..64.
- ES, 2, exponent field width; legal range 0..4, with ES <= N-3.
- RW, $clog2(N)+1, derived: signed regime width.
- FW, N-3-ES, derived: fraction width (hidden bit excluded).
- SW, RW+ES, derived: signed scale width.

Ports:
- clk, input, 1, clock; everything is rising-edge.
- rst_n, input, 1, reset: synchronous, active-low.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, decoder can accept a word this cycle.
- in_posit, input, N, raw posit word.
- out_valid, output, 1, decoded result valid.
- out_ready, input, 1, consumer accepts the result.
- out_sign, output, 1, sign bit of the input.
- out_zero, output, 1, input was all zeros.
- out_nar, output, 1, input was 1 followed by zeros (NaR).
- out_regime, output, RW, signed regime value k.
- out_exponent, output, ES (minimum 1), unsigned exponent field; tied to 0 when ES=0.
- out_fraction, output, FW, fraction bits, left-aligned, zero-padded at the LSBs.
- out_scale, output, SW, signed value k*2^ES + exponent.

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - Stages S1, S2 and S3 each hold a valid bit v1, v2, v3.
  - S3 is the output register.
  - rdy3 = !v3 || out_ready; rdy2 = !v2 || rdy3; rdy1 = !v1 || rdy2; in_ready = rdy1.
  - The ready chain is combinational; bubbles collapse.
- Stage loading:
  - Stage k loads from stage k-1 when rdy_k is high; v_k then takes the upstream valid.
  - When rdy_k is low, stage k holds its value.
  - Payload registers may load regardless of valid; only the valid bits need reset.
- S1: register in_posit and the sign bit (MSB).
  - Form mag = sign ? two's complement of in_posit : in_posit.
  - Flag zero = (in_posit == 0) and nar = (in_posit == 1 followed by N-1 zeros).
- S2: on mag[N-2:0], count the run length m of bits equal to mag[N-2].
  - m is capped at N-1.
  - k = mag[N-2] ? m-1 : -m.
  - Register k and a shifted body with the regime plus its terminator removed.
  - When m = N-1 there is no terminator and the body is empty.
- S3: extract the exponent and fraction from the body.
  - exponent = top ES body bits; bits that do not exist read as 0.
  - fraction = the next FW bits, left-aligned; missing bits read as 0.
  - scale = (k <<< ES) + exponent, sign-extended to SW.
- Special cases:
  - Zero: regime = 0, exponent = 0, fraction = 0, scale = 0, sign = 0, out_zero = 1.
  - NaR: regime = 0, exponent = 0, fraction = 0, scale = 0, sign = 1, out_nar = 1.
- Latency: exactly 3 cycles from input transfer to out_valid when there is no backpressure.
- Throughput: 1 word per cycle.
- Backpressure:
  - While out_valid is high and out_ready is low, every out_* signal holds stable.
  - No word is dropped or duplicated.
  - With all stages full and out_ready low, in_ready = 0.
- Simultaneous events: if out_ready rises in the same cycle that in_valid arrives with the pipe full, the pipe advances and the input is accepted that same cycle.
- Reset:
  - While rst_n = 0 at a clock edge, v1, v2 and v3 clear, so out_valid = 0 and in_ready = 1 on the following cycle.
  - All out_* data outputs reset to 0.
  - Reset mid-stream discards all in-flight words.

Test Plan:
- N=32, ES=2, 0x40000000 -> after 3 cycles: sign 0, regime 0, exponent 0, fraction 0, scale 0. Then 0x48000000 -> regime 0, exponent 1, scale 1, fraction 0.
- N=32, ES=2, 0x00000000 and 0x80000000 -> out_zero=1 for the first, out_nar=1 with sign=1 for the second, all fields 0. Then 0xC0000000 -> sign 1, regime 0, scale 0.
- N=32, ES=2, 0x7FFFFFFF -> regime 30, exponent 0, fraction 0, scale 120. Then 0x00000001 -> regime -30, scale -120.
- Stream 16 back-to-back words with out_ready=1 -> 16 consecutive out_valid cycles, in order, 3-cycle latency. Then hold out_ready=0 for 5 cycles -> in_ready drops after the pipe holds 3 words, outputs stay stable, and no word is lost on release.
- Assert rst_n=0 for 1 cycle with 3 words in flight -> out_valid=0 and in_ready=1 the next cycle, outputs 0, and the pre-reset words never appear.
- N=16, ES=1 and N=8, ES=0, exhaustive sweep of all input values -> every field matches the reference model, including truncated exponent bits, e.g. N=8, ES=0, 0x7E -> regime 5, fraction 0.
